// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
// Writes a COEF_COUNT-word coefficient burst (COEF_COUNT = MEMORY_DEPTH/2)
// from a valid/ready stream into the FIR h memory. A pending or active load
// raises filter_hold_o so no new filter run starts. Writing begins only
// after the filter's h-memory read port (busy_i) is quiet.
//
// Ports
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   load_start_i    : request a load (sampled in IDLE / ERR only)
//   busy_i          : filter h-memory read enable
//   coef_valid_i    : stream beat valid
//   coef_data_i     : stream beat data (FP32 coefficient)
//   coef_last_i     : final beat marker
//   coef_ready_o    : beat accepted when high (high only in LOAD)
//   we_h_o          : registered h-memory write enable
//   addr_h_o        : registered h-memory write address
//   data_h_o        : registered h-memory write data
//   filter_hold_o   : blocks filter ce_i while high
//   load_done_o     : one-cycle pulse on successful completion
//   load_err_o      : framing-error level, cleared by the next start
module fir_coeff_loader #(
  parameter int MEMORY_DEPTH  = 4,
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_start_i,
  input  logic                     busy_i,
  input  logic                     coef_valid_i,
  input  logic [DATA_WIDTH-1:0]    coef_data_i,
  input  logic                     coef_last_i,
  output logic                     coef_ready_o,
  output logic                     we_h_o,
  output logic [ADDRESS_WIDTH-1:0] addr_h_o,
  output logic [DATA_WIDTH-1:0]    data_h_o,
  output logic                     filter_hold_o,
  output logic                     load_done_o,
  output logic                     load_err_o
);

  localparam int COEF_COUNT = MEMORY_DEPTH / 2;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(COEF_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_QUIET,
    LOAD,
    DONE,
    ERR
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] index;

  assign coef_ready_o = (state == LOAD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      index         <= '0;
      we_h_o        <= 1'b0;
      addr_h_o      <= '0;
      data_h_o      <= '0;
      filter_hold_o <= 1'b0;
      load_done_o   <= 1'b0;
      load_err_o    <= 1'b0;
    end else begin
      we_h_o      <= 1'b0;
      load_done_o <= 1'b0;
      case (state)
        IDLE: begin
          index <= '0;
          if (load_start_i) begin
            state         <= WAIT_QUIET;
            filter_hold_o <= 1'b1;
          end
        end
        WAIT_QUIET: begin
          if (!busy_i) state <= LOAD;
        end
        LOAD: begin
          if (coef_valid_i) begin
            we_h_o   <= 1'b1;
            addr_h_o <= index;
            data_h_o <= coef_data_i;
            if (index == LAST_INDEX) begin
              // Final slot: the word is written whether or not framing is right.
              if (coef_last_i) begin
                state <= DONE;
              end else begin
                state      <= ERR;
                load_err_o <= 1'b1;
              end
            end else if (coef_last_i) begin
              state      <= ERR;
              load_err_o <= 1'b1;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        DONE: begin
          // Extra cycle lets the final write land while hold is still high.
          state         <= IDLE;
          filter_hold_o <= 1'b0;
          load_done_o   <= 1'b1;
        end
        ERR: begin
          // Hold stays asserted: the coefficient set is incomplete.
          if (load_start_i) begin
            state      <= WAIT_QUIET;
            load_err_o <= 1'b0;
            index      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

  localparam int CC = 2;

  logic        clk, rst;
  logic        load_start, busy, coef_valid, coef_last;
  logic [31:0] coef_data;
  logic        coef_ready, we_h, filter_hold, load_done, load_err;
  logic [1:0]  addr_h;
  logic [31:0] data_h;

  int checks   = 0;
  int failures = 0;

  fir_coeff_loader #(
    .MEMORY_DEPTH (4),
    .ADDRESS_WIDTH(2),
    .DATA_WIDTH   (32)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_start_i (load_start),
    .busy_i       (busy),
    .coef_valid_i (coef_valid),
    .coef_data_i  (coef_data),
    .coef_last_i  (coef_last),
    .coef_ready_o (coef_ready),
    .we_h_o       (we_h),
    .addr_h_o     (addr_h),
    .data_h_o     (data_h),
    .filter_hold_o(filter_hold),
    .load_done_o  (load_done),
    .load_err_o   (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level expectation: what the outputs must show after each edge.
  typedef struct packed {
    logic        hold;
    logic        ready;
    logic        finishing;
    logic        err;
    logic        done;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] beats;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c, logic start, logic bsy, logic vld,
                                  logic lst, logic [31:0] d);
    model_t n = c;
    n.we   = 1'b0;
    n.done = 1'b0;
    if (c.finishing) begin
      n.finishing = 1'b0;
      n.hold      = 1'b0;
      n.done      = 1'b1;
    end else if (c.ready) begin
      if (vld) begin
        n.we    = 1'b1;
        n.addr  = 2'(c.beats);
        n.data  = d;
        n.beats = c.beats + 1;
        if (n.beats == CC || lst) begin
          n.ready = 1'b0;
          if (n.beats == CC && lst) n.finishing = 1'b1;
          else n.err = 1'b1;
        end
      end
    end else if (c.hold && !c.err) begin
      if (!bsy) n.ready = 1'b1;
    end else if (start) begin
      n.hold  = 1'b1;
      n.err   = 1'b0;
      n.beats = 0;
    end
    return n;
  endfunction

  initial begin
    m = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m = '0;
      else m = step(m, load_start, busy, coef_valid, coef_last, coef_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image and write log as seen from the DUT's write port.
  logic [31:0] dut_mem [4];
  logic [1:0]  wr_addr_q[$];
  int          wr_cnt   = 0;
  int          done_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ready", coef_ready, m.ready);
        chk("hold",  filter_hold, m.hold);
        chk("done",  load_done, m.done);
        chk("err",   load_err, m.err);
        chk("we",    we_h, m.we);
        chk("addr",  addr_h, m.addr);
        chk("data",  data_h, m.data);
        if (we_h) begin
          dut_mem[addr_h] = data_h;
          wr_addr_q.push_back(addr_h);
          wr_cnt++;
        end
        if (load_done) done_cnt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic start_load;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic lst);
    bit ok = 0;
    coef_data  = d;
    coef_last  = lst;
    coef_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (coef_ready) ok = 1;
      tick();
    end
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    if (!ok) chk("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic good_burst;
    send_beat(32'h3F800000, 1'b0);
    send_beat(32'h40000000, 1'b1);
  endtask

  task automatic wait_done;
    int d0 = done_cnt;
    for (int i = 0; i < 10 && done_cnt == d0; i++) tick();
    chk("done_seen", (done_cnt > d0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int w0, d0;

  initial begin
    rst = 1'b1; load_start = 0; busy = 0; coef_valid = 0; coef_last = 0; coef_data = '0;
    for (int i = 0; i < 4; i++) dut_mem[i] = '0;
    #1;
    chk("rst_ready", coef_ready, 0);
    chk("rst_we", we_h, 0);
    chk("rst_addr", addr_h, 0);
    chk("rst_data", data_h, 0);
    chk("rst_hold", filter_hold, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Nominal load
    w0 = wr_cnt; d0 = done_cnt;
    start_load();
    chk("nom_hold_from_start", filter_hold, 1);
    good_burst();
    tick();
    chk("nom_done_pulse", load_done, 1);
    chk("nom_hold_falls", filter_hold, 0);
    tick();
    chk("nom_done_single", load_done, 0);
    chk("nom_writes", wr_cnt - w0, 2);
    chk("nom_mem0", dut_mem[0], 32'h3F800000);
    chk("nom_mem1", dut_mem[1], 32'h40000000);
    chk("nom_addr_order0", wr_addr_q[wr_addr_q.size()-2], 0);
    chk("nom_addr_order1", wr_addr_q[wr_addr_q.size()-1], 1);

    // Busy wait
    busy = 1'b1;
    start_load();
    for (int i = 0; i < 5; i++) begin
      chk("busy_ready_low", coef_ready, 0);
      chk("busy_hold_high", filter_hold, 1);
      tick();
    end
    busy = 1'b0;
    tick();
    chk("busy_ready_rise", coef_ready, 1);
    good_burst();
    wait_done();

    // Early last
    d0 = done_cnt;
    start_load();
    send_beat(32'h11111111, 1'b1);
    tick();
    chk("early_err", load_err, 1);
    chk("early_hold", filter_hold, 1);
    chk("early_mem0", dut_mem[0], 32'h11111111);
    chk("early_no_done", done_cnt - d0, 0);
    start_load();
    chk("early_err_clr", load_err, 0);
    good_burst();
    wait_done();
    chk("early_recover_err", load_err, 0);

    // Missing last
    start_load();
    send_beat(32'hAAAA0001, 1'b0);
    send_beat(32'hBBBB0002, 1'b0);
    tick();
    chk("miss_err", load_err, 1);
    chk("miss_hold", filter_hold, 1);
    chk("miss_mem0", dut_mem[0], 32'hAAAA0001);
    chk("miss_mem1", dut_mem[1], 32'hBBBB0002);
    start_load();
    good_burst();
    wait_done();

    // Backpressure gap
    start_load();
    tick();
    w0 = wr_cnt;
    send_beat(32'hC0000003, 1'b0);
    tick();
    send_beat(32'hD0000004, 1'b1);
    wait_done();
    chk("gap_writes", wr_cnt - w0, 2);
    chk("gap_addr0", wr_addr_q[wr_addr_q.size()-2], 0);
    chk("gap_addr1", wr_addr_q[wr_addr_q.size()-1], 1);
    chk("gap_mem1", dut_mem[1], 32'hD0000004);

    // Asynchronous reset after the first beat
    start_load();
    w0 = wr_cnt;
    send_beat(32'hEEEE0005, 1'b0);
    tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_hold", filter_hold, 0);
    chk("arst_ready", coef_ready, 0);
    chk("arst_we", we_h, 0);
    chk("arst_addr", addr_h, 0);
    chk("arst_data", data_h, 0);
    chk("arst_err", load_err, 0);
    chk("arst_done", load_done, 0);
    chk("arst_one_write", wr_cnt - w0, 1);
    load_start = 1'b1;
    tick(); tick();
    chk("arst_start_ignored", filter_hold, 0);
    #1 rst = 1'b0;
    load_start = 1'b0;
    tick();
    chk("arst_idle_after", filter_hold, 0);
    start_load();
    good_burst();
    wait_done();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      load_start = ($urandom_range(0, 7) == 0);
      busy       = ($urandom_range(0, 2) == 0);
      coef_valid = $urandom_range(0, 1);
      coef_last  = ($urandom_range(0, 2) != 0);
      coef_data  = $urandom;
      tick();
    end
    load_start = 0; busy = 0; coef_valid = 0; coef_last = 0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
